// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, constants and the buffered write-back entry type for the
// register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous FIFO holding mul/div results until the write port is free;
// exposes per-entry valid bits and addresses so the top can build a busy mask.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  wb_entry_t                      push_entry_i,
    input  logic                           pop_i,
    output wb_entry_t                      head_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [DEPTH-1:0]               valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  do_push_s, do_pop_s;

    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign valid_o   = valid_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr_o[i] = mem_q[i].addr;
        end
    end

    // Pop clears the head slot before push fills the tail; they never alias.
    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_pop_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            mem_d[wr_ptr_q]   = push_entry_i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, buffered
// mul/div results drain into idle write-port cycles in arrival order.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_wen_i,
    input  logic [ADDR_W-1:0]             pipe_addr_i,
    input  logic [DATA_W-1:0]             pipe_data_i,
    input  logic                          md_valid_i,
    output logic                          md_ready_o,
    input  logic [ADDR_W-1:0]             md_addr_i,
    input  logic [DATA_W-1:0]             md_data_i,
    output logic [ADDR_W-1:0]             RDaddr_o,
    output logic [DATA_W-1:0]             RDdata_o,
    output logic                          RegWrite_o,
    output logic [NUM_REGS-1:0]           busy_mask_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [CNT_W-1:0]              conflict_cnt_o
);

    logic                               pipe_eff_s;
    logic                               push_s;
    logic                               pop_s;
    logic                               full_s;
    logic                               empty_s;
    wb_entry_t                          push_entry_s;
    wb_entry_t                          head_s;
    logic [FIFO_DEPTH-1:0]              valid_s;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0]  entry_addr_s;
    logic [CNT_W-1:0]                   conflict_q, conflict_d;

    assign pipe_eff_s     = pipe_wen_i && (pipe_addr_i != ZERO_REG);
    assign md_ready_o     = !rst && !full_s;
    // Results for r0 are handshaken away without occupying a buffer slot.
    assign push_s         = md_valid_i && md_ready_o && (md_addr_i != ZERO_REG);
    assign push_entry_s   = '{addr: md_addr_i, data: md_data_i};
    assign conflict_cnt_o = conflict_q;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .head_o       (head_s),
        .count_o      (fifo_count_o),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .valid_o      (valid_s),
        .entry_addr_o (entry_addr_s)
    );

    // Unregistered so pipeline writes keep the register file's same-cycle bypass.
    always_comb begin
        pop_s      = 1'b0;
        RegWrite_o = 1'b0;
        RDaddr_o   = ZERO_REG;
        RDdata_o   = '0;
        if (rst) begin
            pop_s      = 1'b0;
            RegWrite_o = 1'b0;
        end else if (pipe_eff_s) begin
            RegWrite_o = 1'b1;
            RDaddr_o   = pipe_addr_i;
            RDdata_o   = pipe_data_i;
        end else if (!empty_s) begin
            pop_s      = 1'b1;
            RegWrite_o = 1'b1;
            RDaddr_o   = head_s.addr;
            RDdata_o   = head_s.data;
        end else begin
            pop_s      = 1'b0;
            RegWrite_o = 1'b0;
        end
    end

    always_comb begin
        busy_mask_o = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            busy_mask_o = busy_mask_o |
                ({{(NUM_REGS-1){1'b0}}, valid_s[i]} << entry_addr_s[i]);
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (pipe_eff_s && !empty_s && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + CNT_W'(1);
        end else begin
            conflict_d = conflict_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by constrained-random
// traffic, all compared against a queue-based model of the write-port rules.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH   = 2;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      pipe_wen;
    logic [ADDR_W-1:0]         pipe_addr;
    logic [DATA_W-1:0]         pipe_data;
    logic                      md_valid;
    logic                      md_ready;
    logic [ADDR_W-1:0]         md_addr;
    logic [DATA_W-1:0]         md_data;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_data;
    logic                      reg_write;
    logic [NUM_REGS-1:0]       busy_mask;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic [CW-1:0]             conflict_cnt;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_wen_i     (pipe_wen),
        .pipe_addr_i    (pipe_addr),
        .pipe_data_i    (pipe_data),
        .md_valid_i     (md_valid),
        .md_ready_o     (md_ready),
        .md_addr_i      (md_addr),
        .md_data_i      (md_data),
        .RDaddr_o       (rd_addr),
        .RDdata_o       (rd_data),
        .RegWrite_o     (reg_write),
        .busy_mask_o    (busy_mask),
        .fifo_count_o   (fifo_count),
        .conflict_cnt_o (conflict_cnt)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    int   cnt_m = 0;
    int   checks_total = 0;
    int   checks_pass = 0;
    bit   md_hold = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUM_REGS-1:0] model_mask();
        logic [NUM_REGS-1:0] m;
        m = '0;
        foreach (q[i]) m[q[i].addr] = 1'b1;
        return m;
    endfunction

    // Let inputs settle, then compare every output against the model.
    task automatic settle();
        logic              eff;
        logic              ew;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        #2;
        eff = pipe_wen && (pipe_addr != '0);
        ew = 1'b0; ea = '0; ed = '0;
        if (rst) begin
            ew = 1'b0;
        end else if (eff) begin
            ew = 1'b1; ea = pipe_addr; ed = pipe_data;
        end else if (q.size() > 0) begin
            ew = 1'b1; ea = q[0].addr; ed = q[0].data;
        end
        check_eq("regwrite", reg_write, ew);
        check_eq("rdaddr", rd_addr, ea);
        check_eq("rddata", rd_data, ed);
        check_eq("md_ready", md_ready, !rst && (q.size() < DEPTH));
        check_eq("fifo_count", fifo_count, q.size());
        check_eq("busy_mask", busy_mask, model_mask());
        check_eq("conflict_cnt", conflict_cnt, cnt_m);
        if (!rst && eff) check_eq("waw_busy", busy_mask[pipe_addr], 1'b0);
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic clock();
        bit eff;
        bit rdy;
        eff = pipe_wen && (pipe_addr != '0);
        rdy = !rst && (q.size() < DEPTH);
        md_hold = md_valid && !rdy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (eff && q.size() > 0 && cnt_m < CNT_MAX) cnt_m++;
            if (!eff && q.size() > 0) q.delete(0);
            if (md_valid && rdy && md_addr != '0) q.push_back('{addr: md_addr, data: md_data});
        end
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wen = 1'b0; pipe_addr = '0; pipe_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
    endtask

    initial begin
        logic [NUM_REGS-1:0] m;
        rst = 1'b1;
        idle_inputs();
        clock();
        settle();
        check_eq("rst_regwrite", reg_write, 1'b0);
        clock();
        rst = 1'b0;
        settle();
        check_eq("idle_ready", md_ready, 1'b1);
        check_eq("idle_count", fifo_count, 0);
        clock();

        // Single mul/div result with an idle pipeline.
        md_valid = 1'b1; md_addr = 5'd7; md_data = 32'hDEADBEEF;
        settle(); clock();
        md_valid = 1'b0;
        settle();
        check_eq("md7_we", reg_write, 1'b1);
        check_eq("md7_addr", rd_addr, 5'd7);
        check_eq("md7_data", rd_data, 32'hDEADBEEF);
        check_eq("md7_busy", busy_mask, 32'h0000_0080);
        clock();
        settle();
        check_eq("md7_busy_clear", busy_mask, 32'h0);
        clock();

        // Fill the buffer behind four back-to-back pipeline writes.
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h0000_9999;
        settle(); clock();
        pipe_wen = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h3333_0000;
        md_addr = 5'd10; md_data = 32'h0000_AAAA;
        settle(); clock();
        md_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pipe_data = 32'h3333_0001 + 32'(i);
            settle();
            check_eq("full_count", fifo_count, 2);
            check_eq("full_ready", md_ready, 1'b0);
            check_eq("full_mask", busy_mask, 32'h0000_0600);
            clock();
        end
        idle_inputs();
        settle();
        check_eq("conflict4", conflict_cnt, 3'd4);
        check_eq("drain_first", rd_addr, 5'd9);
        clock();
        settle();
        check_eq("drain_second", rd_addr, 5'd10);
        clock();

        // Simultaneous push and pop at count 1.
        pipe_wen = 1'b1; pipe_addr = 5'd3; md_valid = 1'b1; md_addr = 5'd11; md_data = 32'h1111_1111;
        settle(); clock();
        pipe_wen = 1'b0; md_addr = 5'd12; md_data = 32'h1212_1212;
        settle();
        check_eq("pp_head11", rd_addr, 5'd11);
        clock();
        md_valid = 1'b0;
        settle();
        check_eq("pp_count", fifo_count, 1);
        check_eq("pp_head12", rd_addr, 5'd12);
        clock();

        // Address-zero writes on both sides are no-ops.
        pipe_wen = 1'b1; pipe_addr = '0; pipe_data = 32'hFFFF_FFFF;
        md_valid = 1'b1; md_addr = '0; md_data = 32'h5555_5555;
        settle();
        check_eq("zero_we", reg_write, 1'b0);
        clock();
        idle_inputs();
        settle();
        check_eq("zero_count", fifo_count, 0);
        clock();

        // Reset with two entries buffered and a pipeline write pending.
        pipe_wen = 1'b1; pipe_addr = 5'd3; md_valid = 1'b1; md_addr = 5'd20; md_data = 32'h2020_2020;
        settle(); clock();
        md_addr = 5'd21; md_data = 32'h2121_2121;
        settle(); clock();
        md_valid = 1'b0; rst = 1'b1;
        settle();
        check_eq("rst_mid_we", reg_write, 1'b0);
        check_eq("rst_mid_ready", md_ready, 1'b0);
        clock();
        rst = 1'b0; idle_inputs();
        settle();
        check_eq("post_rst_count", fifo_count, 0);
        check_eq("post_rst_conflict", conflict_cnt, 0);
        check_eq("post_rst_ready", md_ready, 1'b1);
        clock();

        // Random traffic honouring the hold-until-accepted and WAW rules.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(63) == 0);
            pipe_wen  = ($urandom_range(1) == 1);
            pipe_addr = ADDR_W'($urandom_range(15));
            pipe_data = $urandom();
            m = model_mask();
            if (pipe_wen && m[pipe_addr]) pipe_wen = 1'b0;
            if (!md_hold) begin
                md_valid = ($urandom_range(2) != 0);
                md_addr  = ($urandom_range(7) == 0) ? '0 : ADDR_W'($urandom_range(31));
                md_data  = $urandom();
            end
            settle();
            clock();
        end

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
